// File: rtl/adaptor_types.sv
// adaptor_types: shared types for the 64-bit, 4-beat cacheline burst protocol
package adaptor_types;
    typedef logic [63:0]  burst_t;
    typedef logic [255:0] line_t;
    localparam int BEATS_PER_LINE   = 4;
    localparam int LINE_OFFSET_BITS = 5;
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_resp_state_t;
endpackage

// File: rtl/pmem_line_ram.sv
// pmem_line_ram: single-port beat-wide line store, synchronous read-first, no reset
module pmem_line_ram
    import adaptor_types::*;
#(
    parameter int DEPTH_LINES = 256
) (
    input  logic                                          clk,
    input  logic [$clog2(DEPTH_LINES*BEATS_PER_LINE)-1:0] addr,
    input  logic                                          we,
    input  logic [63:0]                                   wdata,
    output logic [63:0]                                   q
);
    burst_t mem [DEPTH_LINES*BEATS_PER_LINE];
    // write the addressed beat and register the old contents onto q
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: burst-mode physical-memory slave with programmable access latency
module pmem_responder
    import adaptor_types::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        proto_err
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int LAT_W = $clog2(LATENCY + 1);
    pmem_resp_state_t state, next_state;
    logic [IDX_W-1:0] line;
    logic             op_write;
    logic [LAT_W-1:0] lat_cnt;
    logic [1:0]       beat;
    logic [1:0]       ram_beat;
    logic             ram_we;
    burst_t           ram_q;
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[31:LINE_OFFSET_BITS+IDX_W], pmem_address[LINE_OFFSET_BITS-1:0]};
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end
    // next-state: request starts a transaction, latency then four beats then turnaround
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (pmem_read || pmem_write) ? WAIT : IDLE;
            WAIT:    next_state = (lat_cnt == LAT_W'(1)) ? BURST : WAIT;
            BURST:   next_state = (beat == 2'd3) ? DONE : BURST;
            default: next_state = IDLE;
        endcase
    end
    // request latch, counters, registered beat strobe and sticky protocol error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line      <= '0;
            op_write  <= 1'b0;
            lat_cnt   <= '0;
            beat      <= '0;
            pmem_resp <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            pmem_resp <= (next_state == BURST);
            beat      <= (state == BURST) ? beat + 2'd1 : 2'd0;
            if (state == WAIT) lat_cnt <= lat_cnt - LAT_W'(1);
            if (state == IDLE && (pmem_read || pmem_write)) begin
                line     <= pmem_address[LINE_OFFSET_BITS +: IDX_W];
                op_write <= !pmem_read;
                lat_cnt  <= LAT_W'(LATENCY);
                if (pmem_read && pmem_write) proto_err <= 1'b1;
            end
        end
    end
    // reads prefetch one beat ahead so the registered RAM output lines up with pmem_resp
    assign ram_beat   = (state == BURST && !op_write) ? beat + 2'd1 : beat;
    assign ram_we     = (state == BURST) && op_write;
    assign pmem_rdata = (pmem_resp && !op_write) ? ram_q : '0;
    pmem_line_ram #(.DEPTH_LINES(DEPTH_LINES)) u_ram (
        .clk   (clk),
        .addr  ({line, ram_beat}),
        .we    (ram_we),
        .wdata (pmem_wdata),
        .q     (ram_q)
    );
endmodule
